// File: rtl/apple_iie_timing_generator.sv
// Apple IIe master timing: 14M divider, CPU phase/strobe decode and DRAM strobes, scan counters.
// Define APPLE_IIE_TIMING_LONG_CYCLE_EN to stretch the h_count=64 cycle to 16 ticks.
module apple_iie_timing_generator (
  input  logic       clk_14m,
  input  logic       reset,
  output logic       clk_7m,
  output logic       cref,
  output logic       clk_phi_0,
  output logic       clk_phi_1,
  output logic       clk_q3,
  output logic       pras_n,
  output logic       pcas_n,
  output logic       ax,
  output logic       long_cycle,
  output logic [6:0] h_count,
  output logic [8:0] v_count
);

`ifdef APPLE_IIE_TIMING_LONG_CYCLE_EN
  localparam logic LONG_EN = 1'b1;
`else
  localparam logic LONG_EN = 1'b0;
`endif

  localparam logic [6:0] H_LAST = 7'd64;
  localparam logic [8:0] V_LAST = 9'd261;

  // Per-tick decode masks, bit n = level during tick n (active-low strobes stored as "low" masks).
  localparam logic [15:0] PHI0_MASK    = 16'hFF80;
  localparam logic [15:0] Q3_MASK      = 16'h078F;
  localparam logic [15:0] RAS_LOW_MASK = 16'hFE7C;
  localparam logic [15:0] CAS_LOW_MASK = 16'hF870;
  localparam logic [15:0] AX_MASK      = 16'h0387;

  logic [3:0] tick_reg, tick_next;
  logic [6:0] h_count_reg, h_count_next;
  logic [8:0] v_count_reg, v_count_next;
  logic       clk_7m_reg, cref_reg;
  logic       phi_0_reg, phi_1_reg, q3_reg, pras_n_reg, pcas_n_reg, ax_reg, long_cycle_reg;
  logic       long_now, long_next;
  logic [3:0] last_tick;

  always_comb begin
    long_now     = LONG_EN && (h_count_reg == H_LAST);
    last_tick    = long_now ? 4'd15 : 4'd13;
    tick_next    = tick_reg + 4'd1;
    h_count_next = h_count_reg;
    v_count_next = v_count_reg;
    if (tick_reg == last_tick) begin
      tick_next = 4'd0;
      if (h_count_reg == H_LAST) begin
        h_count_next = 7'd0;
        v_count_next = (v_count_reg == V_LAST) ? 9'd0 : v_count_reg + 9'd1;
      end else begin
        h_count_next = h_count_reg + 7'd1;
      end
    end
    long_next = LONG_EN && (h_count_next == H_LAST);
  end

  // Outputs decode the next tick so they change on the same edge as the counter.
  always_ff @(posedge clk_14m) begin
    if (reset) begin
      tick_reg       <= 4'd0;
      h_count_reg    <= 7'd0;
      v_count_reg    <= 9'd0;
      clk_7m_reg     <= 1'b0;
      cref_reg       <= 1'b0;
      phi_0_reg      <= 1'b0;
      phi_1_reg      <= 1'b1;
      q3_reg         <= 1'b1;
      pras_n_reg     <= 1'b1;
      pcas_n_reg     <= 1'b1;
      ax_reg         <= 1'b1;
      long_cycle_reg <= 1'b0;
    end else begin
      tick_reg       <= tick_next;
      h_count_reg    <= h_count_next;
      v_count_reg    <= v_count_next;
      clk_7m_reg     <= ~clk_7m_reg;
      // clk_7m doubles as the divider phase, so cref never depends on the tick counter.
      cref_reg       <= cref_reg ^ clk_7m_reg;
      phi_0_reg      <= PHI0_MASK[tick_next];
      phi_1_reg      <= ~PHI0_MASK[tick_next];
      q3_reg         <= Q3_MASK[tick_next];
      pras_n_reg     <= ~RAS_LOW_MASK[tick_next];
      pcas_n_reg     <= ~CAS_LOW_MASK[tick_next];
      ax_reg         <= AX_MASK[tick_next];
      long_cycle_reg <= long_next;
    end
  end

  assign clk_7m     = clk_7m_reg;
  assign cref       = cref_reg;
  assign clk_phi_0  = phi_0_reg;
  assign clk_phi_1  = phi_1_reg;
  assign clk_q3     = q3_reg;
  assign pras_n     = pras_n_reg;
  assign pcas_n     = pcas_n_reg;
  assign ax         = ax_reg;
  assign long_cycle = long_cycle_reg;
  assign h_count    = h_count_reg;
  assign v_count    = v_count_reg;

endmodule

// File: tb/tb_apple_iie_timing_generator.sv
// Scoreboard bench for apple_iie_timing_generator; honours APPLE_IIE_TIMING_LONG_CYCLE_EN.
module tb_apple_iie_timing_generator;

  logic       clk_14m = 1'b0;
  logic       reset   = 1'b1;
  logic       clk_7m, cref, clk_phi_0, clk_phi_1, clk_q3, pras_n, pcas_n, ax, long_cycle;
  logic [6:0] h_count;
  logic [8:0] v_count;

`ifdef APPLE_IIE_TIMING_LONG_CYCLE_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif
  localparam int LINE_EDGES = LONG_EN ? 912 : 910;

  apple_iie_timing_generator dut (
    .clk_14m(clk_14m), .reset(reset), .clk_7m(clk_7m), .cref(cref),
    .clk_phi_0(clk_phi_0), .clk_phi_1(clk_phi_1), .clk_q3(clk_q3),
    .pras_n(pras_n), .pcas_n(pcas_n), .ax(ax), .long_cycle(long_cycle),
    .h_count(h_count), .v_count(v_count)
  );

  always #5 clk_14m = ~clk_14m;

  int checks = 0;
  int failures = 0;
  int m_tick, m_h, m_v;
  bit m_c7, m_cref;
  logic [24:0] sb_q[$];

  function automatic logic [24:0] exp_vec(int t, int h, int v, bit c7, bit cr, bit lng);
    bit phi0, q3, ras, cas, axv;
    phi0 = (t >= 7);
    q3   = (t <= 3) || (t >= 7 && t <= 10);
    ras  = !((t >= 2 && t <= 6) || t >= 9);
    cas  = !((t >= 4 && t <= 6) || t >= 11);
    axv  = (t <= 2) || (t >= 7 && t <= 9);
    return {c7, cr, phi0, !phi0, q3, ras, cas, axv, lng, 7'(h), 9'(v)};
  endfunction

  function automatic logic [24:0] obs_vec();
    return {clk_7m, cref, clk_phi_0, clk_phi_1, clk_q3, pras_n, pcas_n, ax, long_cycle, h_count, v_count};
  endfunction

  // Advance the reference model one edge, queue its prediction, then apply the edge to the DUT.
  task automatic clock_edge(input bit rst);
    int last;
    bit old_c7;
    if (rst) begin
      m_tick = 0; m_h = 0; m_v = 0; m_c7 = 0; m_cref = 0;
    end else begin
      last = (LONG_EN && m_h == 64) ? 15 : 13;
      if (m_tick == last) begin
        m_tick = 0;
        if (m_h == 64) begin
          m_h = 0;
          m_v = (m_v == 261) ? 0 : m_v + 1;
        end else m_h = m_h + 1;
      end else m_tick = m_tick + 1;
      old_c7 = m_c7;
      m_c7 = !m_c7;
      if (old_c7) m_cref = !m_cref;
    end
    sb_q.push_back(exp_vec(m_tick, m_h, m_v, m_c7, m_cref, LONG_EN && m_h == 64));
    reset = rst;
    @(posedge clk_14m);
    #1;
  endtask

  task automatic test_reset();
    logic [24:0] e, o;
    for (int i = 0; i < 22; i++) begin
      clock_edge((i < 2) || (i >= 19));
      e = sb_q.pop_front(); o = obs_vec(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_seq step=%0d actual=%h required=%h", i, o, e);
      end
    end
    checks++;
    if ({clk_phi_0, clk_phi_1, clk_q3, pras_n, pcas_n, ax, long_cycle, clk_7m, cref, h_count, v_count} !== {9'b011111000, 7'd0, 9'd0}) begin
      failures++;
      $display("FAIL reset_state actual=%b%b%b%b%b%b%b%b%b h=%0d v=%0d required=011111000 h=0 v=0",
               clk_phi_0, clk_phi_1, clk_q3, pras_n, pcas_n, ax, long_cycle, clk_7m, cref, h_count, v_count);
    end
  endtask

  task automatic test_normal_cycle();
    logic [24:0] e, o;
    logic [13:0] phi_pat, q3_pat, ras_pat, cas_pat, ax_pat;
    logic [4:0] got, want;
    phi_pat = 14'b0000000_1111111;
    q3_pat  = 14'b1111000_1111000;
    ras_pat = 14'b1100000_1100000;
    cas_pat = 14'b1111000_1111000;
    ax_pat  = 14'b1110000_1110000;
    for (int i = 0; i < 14; i++) begin
      if (i > 0) begin
        clock_edge(1'b0);
        e = sb_q.pop_front(); o = obs_vec(); checks++;
        if (o !== e) begin
          failures++;
          $display("FAIL normal_vec tick=%0d actual=%h required=%h", i, o, e);
        end
      end
      got  = {clk_phi_0, clk_q3, pras_n, pcas_n, ax};
      want = {phi_pat[13-i], q3_pat[13-i], ras_pat[13-i], cas_pat[13-i], ax_pat[13-i]};
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL normal_pattern tick=%0d actual=%b required=%b", i, got, want);
      end
    end
  endtask

  task automatic test_line();
    logic [24:0] e, o;
    int phi_hi, ras_lo, cas_lo, long_seen, cont_err, since_cref;
    bit prev_c7, prev_cref;
    phi_hi = 0; ras_lo = 0; cas_lo = 0; long_seen = 0; cont_err = 0; since_cref = -1;
    clock_edge(1'b1);
    void'(sb_q.pop_front());
    prev_c7 = clk_7m; prev_cref = cref;
    for (int i = 0; i < LINE_EDGES; i++) begin
      clock_edge(1'b0);
      e = sb_q.pop_front(); o = obs_vec(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL line_vec edge=%0d actual=%h required=%h", i, o, e);
      end
      if (clk_7m === prev_c7) cont_err++;
      if (since_cref >= 0) since_cref++;
      if (cref !== prev_cref) begin
        if (since_cref != -1 && since_cref != 2) cont_err++;
        since_cref = 0;
      end
      prev_c7 = clk_7m; prev_cref = cref;
      if (long_cycle === 1'b1) long_seen++;
      if (h_count == 7'd64) begin
        if (clk_phi_0 === 1'b1) phi_hi++;
        if (pras_n === 1'b0) ras_lo++;
        if (pcas_n === 1'b0) cas_lo++;
      end
    end
    checks++;
    if (h_count !== 7'd0 || v_count !== 9'd1) begin
      failures++;
      $display("FAIL line_length actual h=%0d v=%0d required h=0 v=1", h_count, v_count);
    end
    checks++;
    if (phi_hi != (LONG_EN ? 9 : 7) || ras_lo != (LONG_EN ? 12 : 10) || cas_lo != (LONG_EN ? 8 : 6)) begin
      failures++;
      $display("FAIL h64_widths actual phi=%0d ras=%0d cas=%0d required phi=%0d ras=%0d cas=%0d",
               phi_hi, ras_lo, cas_lo, LONG_EN ? 9 : 7, LONG_EN ? 12 : 10, LONG_EN ? 8 : 6);
    end
    checks++;
    if (long_seen != (LONG_EN ? 16 : 0)) begin
      failures++;
      $display("FAIL long_cycle_width actual=%0d required=%0d", long_seen, LONG_EN ? 16 : 0);
    end
    checks++;
    if (cont_err != 0) begin
      failures++;
      $display("FAIL clock_continuity actual_errors=%0d required=0", cont_err);
    end
  endtask

  task automatic test_reset_mid_long();
    logic [24:0] e, o;
    clock_edge(1'b1);
    void'(sb_q.pop_front());
    for (int i = 0; i < 64 * 14 + 12; i++) begin
      clock_edge(1'b0);
      e = sb_q.pop_front(); o = obs_vec(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL midlong_vec edge=%0d actual=%h required=%h", i, o, e);
      end
    end
    checks++;
    if (h_count !== 7'd64 || clk_q3 !== 1'b0 || pcas_n !== 1'b0) begin
      failures++;
      $display("FAIL midlong_pos actual h=%0d q3=%b cas=%b required h=64 q3=0 cas=0", h_count, clk_q3, pcas_n);
    end
    clock_edge(1'b1);
    e = sb_q.pop_front(); o = obs_vec(); checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL midlong_reset actual=%h required=%h", o, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [24:0] e, o;
    for (int i = 0; i < 2 * LINE_EDGES + 5; i++) begin
      clock_edge(1'b0);
      e = sb_q.pop_front(); o = obs_vec(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL b2b_vec edge=%0d actual=%h required=%h", i, o, e);
      end
    end
    checks++;
    if (v_count !== 9'd2 || h_count !== 7'd0) begin
      failures++;
      $display("FAIL b2b_lines actual h=%0d v=%0d required h=0 v=2", h_count, v_count);
    end
  endtask

`ifdef APPLE_IIE_TIMING_LONG_CYCLE_EN
  task automatic test_frame_wrap();
    logic [24:0] e, o;
    int max_v;
    max_v = 0;
    clock_edge(1'b1);
    void'(sb_q.pop_front());
    for (int i = 0; i < 912 * 262; i++) begin
      clock_edge(1'b0);
      e = sb_q.pop_front(); o = obs_vec(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL frame_vec edge=%0d actual=%h required=%h", i, o, e);
      end
      if (int'(v_count) > max_v) max_v = int'(v_count);
    end
    checks++;
    if (h_count !== 7'd0 || v_count !== 9'd0 || clk_phi_0 !== 1'b0 || ax !== 1'b1 || max_v != 261) begin
      failures++;
      $display("FAIL frame_wrap actual h=%0d v=%0d phi0=%b ax=%b max_v=%0d required h=0 v=0 phi0=0 ax=1 max_v=261",
               h_count, v_count, clk_phi_0, ax, max_v);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_normal_cycle();
    test_line();
    test_reset_mid_long();
    test_back_to_back();
`ifdef APPLE_IIE_TIMING_LONG_CYCLE_EN
    test_frame_wrap();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
